wg_trig_seq: RTL

//   Trigger sequencer directly upstream of squarewave_gen; its TRIG_OUT drives that block's START.

---
 rtl/wg_trig_seq_pkg.sv | 7 +
 rtl/wg_trig_seq_sync_edge.sv | 23 ++
 rtl/wg_trig_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/wg_trig_seq_pkg.sv
// wg_trig_seq_pkg: sequencer state encoding and default widths shared with squarewave_gen
package wg_trig_seq_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_EXT, ST_RUN} state_t;
   localparam int WG_PERIOD_WIDTH = 32;
   localparam int WG_COUNT_WIDTH  = 16;
   localparam int WG_SYNC_STAGES  = 2;
endpackage

// File: rtl/wg_trig_seq_sync_edge.sv
// wg_trig_seq_sync_edge: multi-flop synchroniser followed by a registered rising-edge pulse
module wg_trig_seq_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic PULSE
);
   logic [STAGES-1:0] sync_q;
   logic              prev;
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= '0;
         prev   <= 1'b0;
         PULSE  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], D};
         prev   <= sync_q[STAGES-1];
         PULSE  <= sync_q[STAGES-1] & ~prev;
      end
   end
endmodule

// File: rtl/wg_trig_seq.sv
// wg_trig_seq: armed burst of evenly spaced trigger pulses, optionally gated by an external edge
module wg_trig_seq
   import wg_trig_seq_pkg::*;
#(
   parameter int PERIOD_WIDTH = WG_PERIOD_WIDTH,
   parameter int COUNT_WIDTH  = WG_COUNT_WIDTH,
   parameter int SYNC_STAGES  = WG_SYNC_STAGES
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [PERIOD_WIDTH-1:0] CFG_PERIOD,
   input  logic [COUNT_WIDTH-1:0]  CFG_NUM,
   input  logic                    CFG_EXT,
   input  logic                    EXT_TRIG,
   input  logic                    ARM,
   input  logic                    ABORT,
   output logic                    TRIG_OUT,
   output logic                    BUSY,
   output logic                    DONE,
   output logic [COUNT_WIDTH-1:0]  TRIG_CNT
);
   state_t                  state;
   logic [PERIOD_WIDTH-1:0] per_m1;
   logic [PERIOD_WIDTH-1:0] cnt;
   logic [COUNT_WIDTH-1:0]  num;
   logic [PERIOD_WIDTH-1:0] cfg_m1;
   logic                    ext_pulse;
   logic                    last;

   wg_trig_seq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .CLK   (CLK),
      .RST   (RST),
      .D     (EXT_TRIG),
      .PULSE (ext_pulse)
   );

   // cnt holds cycles remaining until the next trigger minus one, so period 0 and 1 both reload 0
   assign cfg_m1 = (CFG_PERIOD == '0) ? '0 : CFG_PERIOD - PERIOD_WIDTH'(1);
   assign last   = (num != '0) && TRIG_OUT && (TRIG_CNT == num);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         TRIG_OUT <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         TRIG_CNT <= '0;
         per_m1   <= '0;
         cnt      <= '0;
         num      <= '0;
      end else begin
         TRIG_OUT <= 1'b0;
         DONE     <= 1'b0;
         if (ABORT) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (ARM) begin
                     per_m1   <= cfg_m1;
                     cnt      <= cfg_m1;
                     num      <= CFG_NUM;
                     BUSY     <= 1'b1;
                     state    <= CFG_EXT ? ST_WAIT_EXT : ST_RUN;
                     TRIG_OUT <= ~CFG_EXT;
                     TRIG_CNT <= CFG_EXT ? '0 : COUNT_WIDTH'(1);
                  end
               end
               ST_WAIT_EXT: begin
                  if (ext_pulse) begin
                     state    <= ST_RUN;
                     TRIG_OUT <= 1'b1;
                     TRIG_CNT <= TRIG_CNT + COUNT_WIDTH'(1);
                     cnt      <= per_m1;
                  end
               end
               ST_RUN: begin
                  if (last) begin
                     state <= ST_IDLE;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                  end else if (cnt == '0) begin
                     TRIG_OUT <= 1'b1;
                     TRIG_CNT <= TRIG_CNT + COUNT_WIDTH'(1);
                     cnt      <= per_m1;
                  end else begin
                     cnt <= cnt - PERIOD_WIDTH'(1);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule
